// File: rtl/fp32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp32_pkg
// Description : Shared binary32 constants, field struct and classification
//               helpers for the floating-point datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package fp32_pkg;

    localparam logic [31:0] FP_ONE      = 32'h3F80_0000;
    localparam logic [31:0] FP_ZERO     = 32'h0000_0000;
    localparam logic [31:0] FP_POS_INF  = 32'h7F80_0000;
    localparam logic [31:0] FP_NEG_INF  = 32'hFF80_0000;
    localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] CORDIC_GAIN = 32'h3F1B_74EE;
    localparam int          EXP_BIAS    = 127;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    function automatic logic fp_is_nan(input fp32_t x);
        return (x.exp == 8'hFF) && (x.frac != 23'd0);
    endfunction

    function automatic logic fp_is_inf(input fp32_t x);
        return (x.exp == 8'hFF) && (x.frac == 23'd0);
    endfunction

    // Denormals carry exponent zero and are deliberately treated as zero.
    function automatic logic fp_is_zero(input fp32_t x);
        return (x.exp == 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp32_arith_unit_compare.sv
`default_nettype none
// ============================================================================
// Module      : fp32_compare
// Description : Combinational binary32 magnitude comparator (lt/eq/gr),
//               denormals as zero, unordered when either input is NaN.
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_compare
    import fp32_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_lt,
    output logic        o_eq,
    output logic        o_gr
);

    fp32_t       w_a;
    fp32_t       w_b;
    logic [30:0] w_mag_a;
    logic [30:0] w_mag_b;
    logic        w_unordered;

    assign w_a         = i_a;
    assign w_b         = i_b;
    assign w_mag_a     = fp_is_zero(w_a) ? 31'd0 : i_a[30:0];
    assign w_mag_b     = fp_is_zero(w_b) ? 31'd0 : i_b[30:0];
    assign w_unordered = fp_is_nan(w_a) || fp_is_nan(w_b);

    always_comb begin
        o_lt = 1'b0;
        o_eq = 1'b0;
        o_gr = 1'b0;
        if (w_unordered) begin
            o_lt = 1'b0;
        end else if ((w_mag_a == 31'd0) && (w_mag_b == 31'd0)) begin
            o_eq = 1'b1;
        end else if (w_a.sign != w_b.sign) begin
            o_lt = w_a.sign;
            o_gr = w_b.sign;
        end else if (w_mag_a == w_mag_b) begin
            o_eq = 1'b1;
        end else begin
            // Two negatives order opposite to their magnitudes.
            o_lt = (w_mag_a < w_mag_b) ^ w_a.sign;
            o_gr = (w_mag_a > w_mag_b) ^ w_a.sign;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp32_arith_unit.sv
`default_nettype none
// ============================================================================
// Module      : fp32_arith_unit
// Description : Binary32 add/sub/mul with magnitude compare, one output
//               register stage, round-to-nearest-even, flush-to-zero.
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_arith_unit
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        control,
    input  logic        mul,
    output logic [31:0] result,
    output logic        lt,
    output logic        eq,
    output logic        gr,
    output logic        out_valid
);

    function automatic logic [31:0] fp_add(input fp32_t x, input fp32_t y);
        fp32_t              big;
        fp32_t              sml;
        logic [7:0]         d;
        logic [49:0]        ysh;
        logic [26:0]        xal;
        logic [26:0]        yal;
        logic [26:0]        norm;
        logic [27:0]        sum;
        logic [4:0]         lz;
        logic               found;
        logic               rup;
        logic signed [9:0]  e;
        logic [24:0]        mr;
        logic [31:0]        res;

        big   = x;
        sml   = y;
        d     = 8'd0;
        ysh   = 50'd0;
        xal   = 27'd0;
        yal   = 27'd0;
        norm  = 27'd0;
        sum   = 28'd0;
        lz    = 5'd0;
        found = 1'b0;
        rup   = 1'b0;
        e     = 10'sd0;
        mr    = 25'd0;
        res   = FP_ZERO;

        if (fp_is_nan(x) || fp_is_nan(y)) begin
            res = FP_QNAN;
        end else if (fp_is_inf(x) && fp_is_inf(y)) begin
            res = (x.sign == y.sign) ? {x.sign, 8'hFF, 23'd0} : FP_QNAN;
        end else if (fp_is_inf(x)) begin
            res = {x.sign, 8'hFF, 23'd0};
        end else if (fp_is_inf(y)) begin
            res = {y.sign, 8'hFF, 23'd0};
        end else begin
            if (fp_is_zero(y) || (!fp_is_zero(x) && ({x.exp, x.frac} >= {y.exp, y.frac}))) begin
                big = x;
                sml = y;
            end else begin
                big = y;
                sml = x;
            end
            d   = big.exp - sml.exp;
            xal = fp_is_zero(big) ? 27'd0 : {1'b1, big.frac, 3'b000};
            ysh = {1'b1, sml.frac, 26'd0} >> d;
            // Guard and round bits kept, everything below folds into sticky.
            if (fp_is_zero(sml)) begin
                yal = 27'd0;
            end else if (d > 8'd26) begin
                yal = 27'd1;
            end else begin
                yal = {ysh[49:24], |ysh[23:0]};
            end
            sum = (big.sign == sml.sign) ? ({1'b0, xal} + {1'b0, yal})
                                         : ({1'b0, xal} - {1'b0, yal});
            e   = $signed({2'b00, big.exp});

            if (sum == 28'd0) begin
                res = FP_ZERO;
            end else begin
                if (sum[27]) begin
                    norm = {sum[27:2], sum[1] | sum[0]};
                    e    = e + 10'sd1;
                end else begin
                    for (int i = 26; i >= 0; i--) begin
                        if (!found && sum[i]) begin
                            lz    = 5'(26 - i);
                            found = 1'b1;
                        end
                    end
                    norm = sum[26:0] << lz;
                    e    = e - $signed({5'd0, lz});
                end
                rup = norm[2] & (norm[1] | norm[0] | norm[3]);
                mr  = {1'b0, norm[26:3]} + {24'd0, rup};
                if (mr[24]) begin
                    e = e + 10'sd1;
                end
                if (e >= 10'sd255) begin
                    res = {big.sign, 8'hFF, 23'd0};
                end else if (e <= 10'sd0) begin
                    res = {big.sign, 31'd0};
                end else begin
                    res = {big.sign, e[7:0], (mr[24] ? mr[23:1] : mr[22:0])};
                end
            end
        end
        return res;
    endfunction

    function automatic logic [31:0] fp_mul(input fp32_t x, input fp32_t y);
        logic               s;
        logic [47:0]        p;
        logic [23:0]        m;
        logic               rb;
        logic               st;
        logic               rup;
        logic signed [9:0]  e;
        logic [24:0]        mr;
        logic [31:0]        res;

        s   = x.sign ^ y.sign;
        p   = 48'd0;
        m   = 24'd0;
        rb  = 1'b0;
        st  = 1'b0;
        rup = 1'b0;
        e   = 10'sd0;
        mr  = 25'd0;
        res = FP_ZERO;

        if (fp_is_nan(x) || fp_is_nan(y)) begin
            res = FP_QNAN;
        end else if ((fp_is_inf(x) && fp_is_zero(y)) || (fp_is_zero(x) && fp_is_inf(y))) begin
            res = FP_QNAN;
        end else if (fp_is_inf(x) || fp_is_inf(y)) begin
            res = {s, 8'hFF, 23'd0};
        end else if (fp_is_zero(x) || fp_is_zero(y)) begin
            res = {s, 31'd0};
        end else begin
            p = 48'({1'b1, x.frac}) * 48'({1'b1, y.frac});
            e = $signed({2'b00, x.exp}) + $signed({2'b00, y.exp}) - 10'(EXP_BIAS);
            // Product of two [1,2) significands lies in [1,4): at most one shift.
            if (p[47]) begin
                m  = p[47:24];
                rb = p[23];
                st = |p[22:0];
                e  = e + 10'sd1;
            end else begin
                m  = p[46:23];
                rb = p[22];
                st = |p[21:0];
            end
            rup = rb & (st | m[0]);
            mr  = {1'b0, m} + {24'd0, rup};
            if (mr[24]) begin
                e = e + 10'sd1;
            end
            if (e >= 10'sd255) begin
                res = {s, 8'hFF, 23'd0};
            end else if (e <= 10'sd0) begin
                res = {s, 31'd0};
            end else begin
                res = {s, e[7:0], (mr[24] ? mr[23:1] : mr[22:0])};
            end
        end
        return res;
    endfunction

    fp32_t       w_a;
    fp32_t       w_b;
    fp32_t       w_b_eff;
    logic [31:0] w_result;
    logic        w_lt;
    logic        w_eq;
    logic        w_gr;

    assign w_a     = a;
    assign w_b     = b;
    assign w_b_eff = {b[31] ^ control, b[30:0]};

    always_comb begin
        w_result = FP_ZERO;
        if (mul) begin
            w_result = fp_mul(w_a, w_b);
        end else begin
            w_result = fp_add(w_a, w_b_eff);
        end
    end

    fp32_compare u_compare (
        .i_a  (a),
        .i_b  (b),
        .o_lt (w_lt),
        .o_eq (w_eq),
        .o_gr (w_gr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result    <= FP_ZERO;
            lt        <= 1'b0;
            eq        <= 1'b0;
            gr        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result <= w_result;
                lt     <= w_lt;
                eq     <= w_eq;
                gr     <= w_gr;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp32_arith_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp32_arith_unit
// Description : Self-checking bench: directed vector table, handshake/reset
//               sequences and randomized ops against a real-valued model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp32_arith_unit;
    import fp32_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        control;
    logic        mul;
    logic [31:0] result;
    logic        lt;
    logic        eq;
    logic        gr;
    logic        out_valid;

    int n_checks;
    int n_fail;

    fp32_arith_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .control   (control),
        .mul       (mul),
        .result    (result),
        .lt        (lt),
        .eq        (eq),
        .gr        (gr),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ctl;
        logic        mul;
        logic [31:0] res;
        logic [2:0]  flags;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic real to_real(input logic [31:0] x);
        if (x[30:23] == 8'd0) return 0.0;
        return $bitstoreal({x[31], 11'({3'd0, x[30:23]} + 11'd896), x[22:0], 29'd0});
    endfunction

    // Round a double to binary32 (nearest-even), overflow to Inf, underflow to signed zero.
    function automatic logic [31:0] from_real(input real r);
        logic [63:0] bits;
        int          e;
        int          m;
        bits = $realtobits(r);
        if (r == 0.0) return {bits[63], 31'd0};
        e = int'(bits[62:52]) - 896;
        m = int'({1'b1, bits[51:29]});
        if (bits[28] && ((|bits[27:0]) || (m % 2 == 1))) m = m + 1;
        if (m == (1 << 24)) begin
            m = m / 2;
            e = e + 1;
        end
        if (e >= 255) return {bits[63], 8'hFF, 23'd0};
        if (e <= 0) return {bits[63], 31'd0};
        return {bits[63], 8'(e), 23'(m)};
    endfunction

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction

    function automatic logic [31:0] model_result(input logic [31:0] x, input logic [31:0] y,
                                                 input logic ctl, input logic m);
        logic [31:0] yy;
        real         r;
        if (is_nan(x) || is_nan(y)) return FP_QNAN;
        if (m) begin
            if ((is_inf(x) && y[30:23] == 8'd0) || (is_inf(y) && x[30:23] == 8'd0)) return FP_QNAN;
            if (is_inf(x) || is_inf(y)) return {x[31] ^ y[31], 8'hFF, 23'd0};
            if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return {x[31] ^ y[31], 31'd0};
            return from_real(to_real(x) * to_real(y));
        end
        yy = {y[31] ^ ctl, y[30:0]};
        if (is_inf(x) && is_inf(yy)) return (x[31] == yy[31]) ? x : FP_QNAN;
        if (is_inf(x)) return x;
        if (is_inf(yy)) return yy;
        r = to_real(x) + to_real(yy);
        if (r == 0.0) return FP_ZERO;
        return from_real(r);
    endfunction

    function automatic logic [2:0] model_flags(input logic [31:0] x, input logic [31:0] y);
        real rx;
        real ry;
        if (is_nan(x) || is_nan(y)) return 3'b000;
        rx = is_inf(x) ? (x[31] ? -1.0e300 : 1.0e300) : to_real(x);
        ry = is_inf(y) ? (y[31] ? -1.0e300 : 1.0e300) : to_real(y);
        return {rx < ry, rx == ry, rx > ry};
    endfunction

    function automatic logic [31:0] rand_fp();
        int          k;
        logic        s;
        logic [22:0] f;
        k = $urandom_range(0, 19);
        s = 1'($urandom);
        f = 23'($urandom);
        case (k)
            0:       return {s, 31'd0};
            1:       return {s, 8'hFF, 23'd0};
            2:       return {s, 8'hFF, f | 23'd1};
            3:       return {s, 8'd0, f};
            4:       return {s, ($urandom_range(0, 1) == 1) ? 8'd1 : 8'd254, f};
            default: return {s, 8'($urandom_range(110, 145)), f};
        endcase
    endfunction

    initial begin
        logic [31:0] exp_res;
        logic [2:0]  exp_flags;
        logic        exp_v;

        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = 32'd0;
        b        = 32'd0;
        control  = 1'b0;
        mul      = 1'b0;

        vecs[0]  = '{FP_ONE,       FP_ONE,       1'b0, 1'b0, 32'h4000_0000, 3'b010};
        vecs[1]  = '{32'h40C9_0FDB, 32'hBF80_0000, 1'b0, 1'b0, 32'h40A9_0FDB, 3'b001};
        vecs[2]  = '{FP_ONE,       FP_ONE,       1'b1, 1'b0, FP_ZERO,       3'b010};
        vecs[3]  = '{32'h4000_0000, CORDIC_GAIN,  1'b0, 1'b1, 32'h3F9B_74EE, 3'b001};
        vecs[4]  = '{32'h7F7F_FFFF, 32'h4000_0000, 1'b0, 1'b1, FP_POS_INF,    3'b001};
        vecs[5]  = '{FP_ONE,       32'h3FC9_0FDB, 1'b0, 1'b0, 32'h4024_87EE, 3'b100};
        vecs[6]  = '{FP_ZERO,      32'h8000_0000, 1'b0, 1'b0, FP_ZERO,       3'b010};
        vecs[7]  = '{FP_QNAN,      FP_ONE,       1'b0, 1'b0, FP_QNAN,       3'b000};
        vecs[8]  = '{FP_POS_INF,   FP_POS_INF,   1'b1, 1'b0, FP_QNAN,       3'b010};
        vecs[9]  = '{FP_ZERO,      FP_POS_INF,   1'b0, 1'b1, FP_QNAN,       3'b100};
        vecs[10] = '{32'hBF80_0000, 32'hC000_0000, 1'b0, 1'b0, 32'hC040_0000, 3'b001};
        vecs[11] = '{32'h0040_0000, FP_ONE,       1'b0, 1'b0, FP_ONE,        3'b100};
        vecs[12] = '{FP_NEG_INF,   FP_ONE,       1'b0, 1'b0, FP_NEG_INF,    3'b100};
        vecs[13] = '{32'h0080_0000, 32'h00C0_0000, 1'b1, 1'b0, 32'h8000_0000, 3'b100};
        vecs[14] = '{FP_ONE,       32'hBF80_0000, 1'b0, 1'b1, 32'hBF80_0000, 3'b001};
        vecs[15] = '{32'h7F00_0000, 32'h7F00_0000, 1'b0, 1'b0, FP_POS_INF,    3'b010};

        #1;
        check("reset_result", result, 32'd0);
        check("reset_flags", {29'd0, lt, eq, gr}, 32'd0);
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        step();
        rst = 1'b0;

        // Directed table, issued back to back.
        for (int i = 0; i < 16; i++) begin
            a        = vecs[i].a;
            b        = vecs[i].b;
            control  = vecs[i].ctl;
            mul      = vecs[i].mul;
            in_valid = 1'b1;
            step();
            check($sformatf("vec%0d_result", i), result, vecs[i].res);
            check($sformatf("vec%0d_flags", i), {29'd0, lt, eq, gr}, {29'd0, vecs[i].flags});
            check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
        end

        // Single op followed by idle cycles: valid pulses once, outputs hold.
        a = FP_ONE; b = 32'h4000_0000; control = 1'b0; mul = 1'b0; in_valid = 1'b1;
        step();
        check("hold_issue_result", result, 32'h4040_0000);
        check("hold_issue_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        a = 32'hC2C8_0000; b = 32'h4120_0000; mul = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hold%0d_valid", i), {31'd0, out_valid}, 32'd0);
            check($sformatf("hold%0d_result", i), result, 32'h4040_0000);
            check($sformatf("hold%0d_flags", i), {29'd0, lt, eq, gr}, 32'b100);
        end

        // Asynchronous reset between clock edges while a result is showing.
        a = FP_ONE; b = FP_ONE; control = 1'b0; mul = 1'b0; in_valid = 1'b1;
        step();
        check("prerst_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("asyncrst_result", result, 32'd0);
        check("asyncrst_flags", {29'd0, lt, eq, gr}, 32'd0);
        check("asyncrst_valid", {31'd0, out_valid}, 32'd0);
        #2 rst = 1'b0;
        a = 32'h4000_0000; b = 32'h4000_0000; mul = 1'b1; in_valid = 1'b1;
        step();
        check("postrst_result", result, 32'h4080_0000);
        check("postrst_flags", {29'd0, lt, eq, gr}, 32'b010);
        check("postrst_valid", {31'd0, out_valid}, 32'd1);

        // Randomized traffic with sporadic idle cycles.
        exp_res   = 32'h4080_0000;
        exp_flags = 3'b010;
        for (int i = 0; i < 400; i++) begin
            a = rand_fp();
            b = ($urandom_range(0, 7) == 0) ? {1'($urandom), a[30:0]} : rand_fp();
            control  = 1'($urandom);
            mul      = ($urandom_range(0, 2) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            exp_v    = in_valid;
            if (in_valid) begin
                exp_res   = model_result(a, b, control, mul);
                exp_flags = model_flags(a, b);
            end
            step();
            check($sformatf("rnd%0d_valid", i), {31'd0, out_valid}, {31'd0, exp_v});
            check($sformatf("rnd%0d_result a=%08h b=%08h c=%0b m=%0b", i, a, b, control, mul),
                  result, exp_res);
            check($sformatf("rnd%0d_flags a=%08h b=%08h", i, a, b),
                  {29'd0, lt, eq, gr}, {29'd0, exp_flags});
        end

        in_valid = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
